relu_backward: RTL and testbench

RELU_BACKWARD -- requirements
Module: relu_backward

---
 rtl/relu_backward.sv | 109 ++++++++++
 tb/tb_relu_backward.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/relu_backward.sv
// ReLU backward pass over a square feature map: masks the upstream gradient
// wherever the forward pre-activation was not strictly positive, LANES elements per cycle.

module relu_backward_lane (
  input  logic [31:0] fwd,
  input  logic [31:0] grad,
  output logic [31:0] masked,
  output logic        active
);
  // Strictly positive in two's complement: zero and the most negative value both fail.
  assign active = $signed(fwd) > 32'sd0;
  assign masked = active ? grad : '0;
endmodule

module relu_backward #(
  parameter int MAP_WIDTH = 4,
  parameter int LANES     = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [MAP_WIDTH*MAP_WIDTH*32-1:0]            fwd_map,
  input  logic [MAP_WIDTH*MAP_WIDTH*32-1:0]            grad_in,
  output logic [MAP_WIDTH*MAP_WIDTH*32-1:0]            grad_out,
  output logic [$clog2(MAP_WIDTH*MAP_WIDTH+1)-1:0]     active_count,
  output logic                                         busy,
  output logic                                         done
);
  localparam int N  = MAP_WIDTH * MAP_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - LANES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [IW-1:0]          idx;
  logic [N-1:0][31:0]     buf_fwd, buf_grad, go_q;
  logic [CW-1:0]          cnt_q;

  logic [LANES-1:0][31:0] lane_fwd, lane_grad, lane_out;
  logic [LANES-1:0]       lane_act;
  logic [CW-1:0]          chunk_cnt;

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      assign lane_fwd[l]  = buf_fwd[idx + IW'(l)];
      assign lane_grad[l] = buf_grad[idx + IW'(l)];
      relu_backward_lane u_lane (
        .fwd    (lane_fwd[l]),
        .grad   (lane_grad[l]),
        .masked (lane_out[l]),
        .active (lane_act[l])
      );
    end
  endgenerate

  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < LANES; i++) chunk_cnt = chunk_cnt + CW'(lane_act[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      go_q     <= '0;
      cnt_q    <= '0;
      idx      <= '0;
      buf_fwd  <= '0;
      buf_grad <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Results of the previous pass hold here until a new pass is accepted.
          if (start) begin
            buf_fwd  <= fwd_map;
            buf_grad <= grad_in;
            go_q     <= '0;
            cnt_q    <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < LANES; i++) go_q[idx + IW'(i)] <= lane_out[i];
          cnt_q <= cnt_q + chunk_cnt;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(LANES);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign grad_out     = go_q;
  assign active_count = cnt_q;
endmodule

// File: tb/tb_relu_backward.sv
// Directed + randomized bench for relu_backward; runs a 1-lane and a 4-lane instance side by side.

module tb_relu_backward;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset, start1, start4;
  logic [N*32-1:0] fwd_map, grad_in, go1, go4;
  logic [4:0] ac1, ac4;
  logic busy1, busy4, done1, done4;

  logic [31:0] f[N], g[N], cf[N], cg[N];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  relu_backward #(.MAP_WIDTH(4), .LANES(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .fwd_map(fwd_map), .grad_in(grad_in),
    .grad_out(go1), .active_count(ac1), .busy(busy1), .done(done1));
  relu_backward #(.MAP_WIDTH(4), .LANES(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .fwd_map(fwd_map), .grad_in(grad_in),
    .grad_out(go4), .active_count(ac4), .busy(busy4), .done(done4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N*32-1:0] obs, input logic [N*32-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      fwd_map[i*32 +: 32] = f[i];
      grad_in[i*32 +: 32] = g[i];
    end
  endtask

  task automatic capture();
    for (int i = 0; i < N; i++) begin
      cf[i] = f[i];
      cg[i] = g[i];
    end
  endtask

  // Reference: first nproc elements processed, positive forward passes gradient through.
  function automatic logic [N*32-1:0] model_out(input int nproc);
    logic [N*32-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (i < nproc && int'(cf[i]) > 0) r[i*32 +: 32] = cg[i];
    return r;
  endfunction

  function automatic int model_cnt(input int nproc);
    int c = 0;
    for (int i = 0; i < N; i++)
      if (i < nproc && int'(cf[i]) > 0) c++;
    return c;
  endfunction

  task automatic load_basic();
    for (int i = 0; i < N; i++) begin
      f[i] = 32'(i - 8);
      g[i] = 32'(100 + i);
    end
  endtask

  // Full pass on both instances with per-edge busy/done/partial-result checks.
  task automatic run_pass(input string tag, input bit clobber);
    int n4;
    apply();
    capture();
    start1 = 1'b1; start4 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    if (clobber) begin
      fwd_map = '1;
      grad_in = '1;
    end
    chk({tag, " accept busy1"}, busy1, 1'b1);
    chk({tag, " accept done4"}, done4, 1'b0);
    chk({tag, " accept go1"}, go1, '0);
    for (int k = 1; k <= N; k++) begin
      tick();
      n4 = (k * 4 > N) ? N : k * 4;
      chk($sformatf("%s busy1 e%0d", tag, k), busy1, k < N);
      chk($sformatf("%s done1 e%0d", tag, k), done1, k == N);
      chk($sformatf("%s busy4 e%0d", tag, k), busy4, k < 4);
      chk($sformatf("%s done4 e%0d", tag, k), done4, k >= 4);
      chk($sformatf("%s go1 e%0d", tag, k), go1, model_out(k));
      chk($sformatf("%s ac1 e%0d", tag, k), ac1, 5'(model_cnt(k)));
      chk($sformatf("%s go4 e%0d", tag, k), go4, model_out(n4));
      chk($sformatf("%s ac4 e%0d", tag, k), ac4, 5'(model_cnt(n4)));
    end
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    fwd_map = '0; grad_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset go1", go1, '0);
    chk("reset go4", go4, '0);
    chk("reset ac1", ac1, 5'd0);
    chk("reset busy/done", {busy1, done1, busy4, done4}, 4'b0000);

    // Basic pass, then hold in DONE
    load_basic();
    run_pass("basic", 1'b0);
    chk("basic ac1 is 7", ac1, 5'd7);
    chk("basic go1[8]", go1[8*32 +: 32], 32'd0);
    chk("basic go1[9]", go1[9*32 +: 32], 32'd109);
    chk("basic go1[15]", go1[15*32 +: 32], 32'd115);
    chk("basic lanes agree", go4, go1);
    repeat (3) tick();
    chk("hold done1", done1, 1'b1);
    chk("hold go1", go1, model_out(N));
    chk("hold ac4", ac4, 5'd7);

    // Sign and zero edge cases with the most negative gradient everywhere
    for (int i = 0; i < N; i++) begin
      f[i] = $urandom;
      g[i] = 32'h80000000;
    end
    f[0] = 32'd0; f[1] = 32'd1; f[2] = 32'hFFFFFFFF; f[3] = 32'h7FFFFFFF; f[4] = 32'h80000000;
    run_pass("sign", 1'b0);
    chk("sign fwd=0", go1[0*32 +: 32], 32'd0);
    chk("sign fwd=1", go1[1*32 +: 32], 32'h80000000);
    chk("sign fwd=-1", go1[2*32 +: 32], 32'd0);
    chk("sign fwd=max", go1[3*32 +: 32], 32'h80000000);
    chk("sign fwd=min", go4[4*32 +: 32], 32'd0);

    // Inputs change right after the accepting edge
    load_basic();
    run_pass("capture", 1'b1);

    // Randomized maps, some zeros forced in
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        f[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        g[i] = $urandom;
      end
      run_pass($sformatf("rand%0d", r), 1'b0);
    end

    // Start during RUN ignored; start while done accepted
    load_basic();
    apply();
    capture();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= N; k++) begin
      start1 = (k == 5);
      tick();
      start1 = 1'b0;
      if (k < N) chk($sformatf("ignore busy1 e%0d", k), busy1, 1'b1);
    end
    chk("ignore done1 on edge 16", done1, 1'b1);
    chk("ignore go1", go1, model_out(N));
    for (int i = 0; i < N; i++) begin
      f[i] = $urandom;
      g[i] = $urandom;
    end
    apply();
    capture();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("b2b done1 drops", done1, 1'b0);
    chk("b2b busy1 rises", busy1, 1'b1);
    chk("b2b go1 cleared", go1, '0);
    repeat (N) tick();
    chk("b2b done1", done1, 1'b1);
    chk("b2b go1", go1, model_out(N));
    chk("b2b ac1", ac1, 5'(model_cnt(N)));

    // Reset at RUN edge 5
    load_basic();
    apply();
    start1 = 1'b1; start4 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort go1", go1, '0);
    chk("abort go4", go4, '0);
    chk("abort ac", {ac1, ac4}, 10'd0);
    chk("abort busy/done", {busy1, done1, busy4, done4}, 4'b0000);
    tick();
    chk("abort stays idle", {busy1, done1, busy4, done4}, 4'b0000);
    run_pass("after-reset", 1'b0);
    chk("after-reset ac4 is 7", ac4, 5'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
